// File: rtl/led_pkg.sv
// led_pkg: shared defaults and scheduler state type for the LED panel row path.
package led_pkg;
    localparam int LED_ROW_W         = 6;
    localparam int LED_BRIGHT_W      = 8;
    localparam int LED_ON_SHIFT      = 2;
    localparam int LED_BLANK_CYCLES  = 4;
    localparam int LED_SETTLE_CYCLES = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SETTLE, ST_ON} led_sched_state_t;
endpackage

// File: rtl/led_row_scheduler_if.sv
// led_row_scheduler_if: latch/brightness controls in, panel row address and OE out.
interface led_row_scheduler_if #(
    parameter int ROW_W    = led_pkg::LED_ROW_W,
    parameter int BRIGHT_W = led_pkg::LED_BRIGHT_W
);
    logic                enable, lat_in, overrun_clr, led_oe, busy, overrun;
    logic [ROW_W-1:0]    row_in, row_addr;
    logic [BRIGHT_W-1:0] brightness;
    modport master (output enable, lat_in, row_in, brightness, overrun_clr,
                    input  row_addr, led_oe, busy, overrun);
    modport slave  (input  enable, lat_in, row_in, brightness, overrun_clr,
                    output row_addr, led_oe, busy, overrun);
endinterface

// File: rtl/led_cycle_counter.sv
// led_cycle_counter: loadable down-counter; o_done marks the last cycle of a loaded count.
module led_cycle_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/led_row_scheduler.sv
// led_row_scheduler: per latched row, blank OE, switch row address, settle, then
// enable the LEDs for brightness << ON_SHIFT cycles.
module led_row_scheduler import led_pkg::*; #(
    parameter int ROW_W         = LED_ROW_W,
    parameter int BRIGHT_W      = LED_BRIGHT_W,
    parameter int ON_SHIFT      = LED_ON_SHIFT,
    parameter int BLANK_CYCLES  = LED_BLANK_CYCLES,
    parameter int SETTLE_CYCLES = LED_SETTLE_CYCLES
) (
    input logic                i2s_clk,
    input logic                rst,
    led_row_scheduler_if.slave bus
);
    localparam int CW = BRIGHT_W + ON_SHIFT;
    led_sched_state_t r_state;
    logic [ROW_W-1:0] r_pend;
    logic [CW-1:0]    w_on, w_val;
    logic             w_done, w_lat, w_load, w_on_end;
    always_comb begin
        w_on     = CW'(bus.brightness) << ON_SHIFT;
        w_lat    = bus.enable && bus.lat_in;
        w_on_end = r_state == ST_ON && w_done;
        w_load   = w_lat || (w_done && (r_state == ST_BLANK || (r_state == ST_SETTLE && w_on != '0)));
        w_val    = w_lat ? CW'(BLANK_CYCLES) : r_state == ST_BLANK ? CW'(SETTLE_CYCLES) : w_on;
    end
    led_cycle_counter #(.W(CW)) u_cnt (
        .clk(i2s_clk), .rst(rst), .i_load(w_load), .i_val(w_val), .o_done(w_done)
    );
    // A latch on the edge where ON ends is a normal back-to-back row, not an overrun.
    always_ff @(posedge i2s_clk or posedge rst)
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pend       <= '0;
            bus.row_addr <= '0;
            bus.led_oe   <= 1'b1;
            bus.busy     <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (bus.overrun_clr) bus.overrun <= 1'b0;
            if (!bus.enable) begin
                r_state    <= ST_IDLE;
                bus.led_oe <= 1'b1;
                bus.busy   <= 1'b0;
            end else if (bus.lat_in) begin
                r_pend     <= bus.row_in;
                r_state    <= ST_BLANK;
                bus.led_oe <= 1'b1;
                bus.busy   <= 1'b1;
                if (r_state != ST_IDLE && !w_on_end) bus.overrun <= 1'b1;
            end else if (w_done) begin
                case (r_state)
                    ST_BLANK: begin
                        bus.row_addr <= r_pend;
                        r_state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        bus.led_oe <= w_on == '0;
                        bus.busy   <= w_on != '0;
                        r_state    <= w_on == '0 ? ST_IDLE : ST_ON;
                    end
                    ST_ON: begin
                        bus.led_oe <= 1'b1;
                        bus.busy   <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_led_row_scheduler.sv
// tb_led_row_scheduler: directed + random stimulus, timeline reference model, scoreboard monitor.
module tb_led_row_scheduler;
    import led_pkg::*;
    typedef struct packed {
        logic [5:0] ra;
        logic       oe;
        logic       busy;
        logic       ovr;
    } obs_t;
    logic clk = 1'b0, rst = 1'b1;
    led_row_scheduler_if bus ();
    led_row_scheduler dut (.i2s_clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    obs_t q[$];
    int   checks = 0, errors = 0;
    event probe;
    // Reference model: time since the accepted latch decides every output.
    int       n = 0, t0 = 0, on_end = 0;
    bit       act = 0, m_oe = 1, m_ovr = 0;
    bit [5:0] m_ra = 0, m_pend = 0;
    localparam int ADDR_AT = LED_BLANK_CYCLES;
    localparam int OE_AT   = LED_BLANK_CYCLES + LED_SETTLE_CYCLES;
    task automatic model_reset();
        act = 0; m_oe = 1; m_ovr = 0; m_ra = 0; m_pend = 0;
    endtask
    task automatic push_exp();
        q.push_back(obs_t'{m_ra, m_oe, act, m_ovr});
    endtask
    task automatic model_edge();
        n++;
        if (rst) model_reset();
        else begin
            if (bus.overrun_clr) m_ovr = 0;
            if (!bus.enable) begin
                act = 0; m_oe = 1;
            end else if (bus.lat_in) begin
                if (act && !(!m_oe && n == on_end)) m_ovr = 1;
                act = 1; t0 = n; m_pend = bus.row_in; m_oe = 1;
            end else if (act) begin
                if (n - t0 == ADDR_AT) m_ra = m_pend;
                if (n - t0 == OE_AT) begin
                    on_end = n + int'(bus.brightness) * (1 << LED_ON_SHIFT);
                    act = on_end != n;
                    m_oe = on_end == n;
                end else if (!m_oe && n == on_end) begin
                    act = 0; m_oe = 1;
                end
            end
        end
        push_exp();
    endtask
    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask
    initial forever begin
        obs_t e;
        @(negedge clk or probe);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("row_addr", int'(bus.row_addr), int'(e.ra));
            chk("led_oe", int'(bus.led_oe), int'(e.oe));
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("overrun", int'(bus.overrun), int'(e.ovr));
        end
    end
    task automatic step(bit en, bit lat, logic [5:0] row, logic [7:0] br, bit clr);
        bus.enable = en; bus.lat_in = lat; bus.row_in = row; bus.brightness = br; bus.overrun_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic idle(int k, logic [7:0] br);
        repeat (k) step(1'b1, 1'b0, 6'($urandom), br, 1'b0);
    endtask
    initial begin
        bus.enable = 1; bus.lat_in = 0; bus.row_in = 0; bus.brightness = 0; bus.overrun_clr = 0;
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 6'(i + 1), 8'd10, 1'b0);
        rst = 0;
        idle(2, 8'd10);
        step(1'b1, 1'b1, 6'd5, 8'd10, 1'b0);
        idle(60, 8'd10);
        step(1'b1, 1'b1, 6'd3, 8'd0, 1'b0);
        idle(20, 8'd0);
        step(1'b1, 1'b1, 6'd7, 8'd10, 1'b0);
        idle(31, 8'd10);
        step(1'b1, 1'b1, 6'd9, 8'd12, 1'b0);
        idle(70, 8'd12);
        step(1'b1, 1'b0, 6'd0, 8'd12, 1'b1);
        idle(2, 8'd12);
        step(1'b1, 1'b1, 6'd2, 8'd1, 1'b0);
        idle(15, 8'd1);
        step(1'b1, 1'b1, 6'd4, 8'd1, 1'b0);
        idle(20, 8'd1);
        step(1'b1, 1'b1, 6'd11, 8'd20, 1'b0);
        idle(22, 8'd20);
        #5 rst = 1;
        #1 model_reset();
        push_exp();
        -> probe;
        idle(2, 8'd20);
        rst = 0;
        idle(3, 8'd20);
        step(1'b1, 1'b1, 6'd33, 8'd255, 1'b0);
        idle(1040, 8'd255);
        step(1'b1, 1'b1, 6'd40, 8'd255, 1'b0);
        idle(112, 8'd255);
        step(1'b0, 1'b0, 6'd0, 8'd255, 1'b0);
        step(1'b0, 1'b1, 6'd41, 8'd255, 1'b0);
        idle(30, 8'd255);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 24) == 0, 6'($urandom),
                 $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom_range(0, 12)),
                 $urandom_range(0, 40) == 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_row_scheduler.md
# led_row_scheduler

Sequences the panel's row address and active-low output enable after each latch from the I2S stream splitter. Each `led_lat` pulse hands over a freshly shifted row and its row number; this block blanks the outputs, switches the row address, waits for the drivers to settle, then enables the LEDs for a brightness-weighted on-time. It sits between the stream splitter's `led_lat`/`row_num` outputs and the panel's row-address and OE pins, and it owns `led_oe` exclusively.

## Interface
- `ROW_W`, 6: row address width; matches `row_num`.
- `BRIGHT_W`, 8: brightness word width.
- `ON_SHIFT`, 2: on-time scale; on-time in cycles = `brightness << ON_SHIFT`.
- `BLANK_CYCLES`, 4: OE-high cycles before the row address changes (≥1).
- `SETTLE_CYCLES`, 8: OE-high cycles after the row address changes (≥1).

Ports:
- `i2s_clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: when low, forces IDLE and OE high.
- `lat_in`  in  1: one-cycle latch pulse from the stream splitter.
- `row_in`  in  ROW_W: row number, valid while `lat_in` is high.
- `brightness`  in  BRIGHT_W: global brightness, sampled at SETTLE exit.
- `overrun_clr`  in  1: clears `overrun`.
- `row_addr`  out  ROW_W: registered row address to the panel.
- `led_oe`  out  1: registered, active-low output enable; 1 = LEDs off.
- `busy`  out  1: registered; high whenever state ≠ IDLE.
- `overrun`  out  1: sticky; a latch arrived before the previous row finished.

## Operation
- Reset values: state IDLE, `row_addr`=0, `led_oe`=1, `busy`=0, `overrun`=0, counters 0, pending row 0.
- States: IDLE, BLANK, SETTLE, ON.
- IDLE: `led_oe`=1. On `lat_in` with `enable`=1: capture `row_in` into the pending row, load the counter with BLANK_CYCLES, and go to BLANK.
- BLANK: `led_oe`=1; count down. On expiry: `row_addr` takes the pending row, load SETTLE_CYCLES, and go to SETTLE.
- SETTLE: `led_oe`=1; count down. On expiry: compute `on = brightness << ON_SHIFT` (BRIGHT_W+ON_SHIFT bits, no truncation).
  - `on`=0: go to IDLE; OE never asserts.
  - Otherwise: load `on`, set `led_oe`=0, and go to ON.
- ON: `led_oe`=0 for exactly `on` cycles, then `led_oe`=1 and go to IDLE.
- `lat_in` in BLANK, SETTLE or ON:
  - Capture `row_in`, set `overrun`=1, reload BLANK_CYCLES, and go to BLANK.
  - From ON, `led_oe` returns to 1 on that same edge.
  - `row_addr` is untouched until the new BLANK expires.
- `overrun_clr` together with an overrunning `lat_in`: the set wins.
- `enable`=0: next edge forces IDLE with `led_oe`=1. `row_addr` holds its value, and `lat_in` is ignored.
- Brightness changes during ON do not affect the current row.

## Timing
- Edge E0 samples `lat_in`=1; `busy`=1 from E0.
- `row_addr` changes at E(BLANK_CYCLES).
- `led_oe` falls at E(BLANK_CYCLES+SETTLE_CYCLES) and rises at E(BLANK_CYCLES+SETTLE_CYCLES+on).
- `busy` falls on the same edge that `led_oe` rises.
- With `on`=0, `busy` falls at E(BLANK_CYCLES+SETTLE_CYCLES).
- Back-to-back: `lat_in` on the edge where ON ends is taken as an IDLE-entry latch. It does not set `overrun`.
- `rst` asserted at any time: all outputs take their reset values immediately, without waiting for a clock edge. LEDs are off from the moment of reset.
- All outputs are glitch-free registers; there is no combinational path from any input to any output.

## Structure
- Shared package `led_pkg` holds:
  - state enum `led_sched_state_t`;
  - default constants `LED_ROW_W`, `LED_BRIGHT_W`, `LED_ON_SHIFT`, `LED_BLANK_CYCLES`, `LED_SETTLE_CYCLES`.
- The stream splitter also imports `LED_ROW_W` from `led_pkg`.
- Natural sub-module: `led_cycle_counter`, a loadable down-counter with a `done` flag. One instance is shared by BLANK, SETTLE and ON, width BRIGHT_W+ON_SHIFT.

## Test plan
All scenarios use default parameters.
- Reset with `lat_in` toggling → `row_addr`=0, `led_oe`=1, `busy`=0, `overrun`=0 throughout.
- `lat_in` with `row_in`=5 and `brightness`=10, sampled at E0 → `row_addr`=5 at E4, `led_oe` low E12 through E52 (40 cycles), `busy` falls at E52, `overrun`=0.
- `brightness`=0 with `row_in`=3 → `row_addr`=3 at E4, `led_oe` never low, `busy` falls at E12.
- Second `lat_in` with `row_in`=9, 20 cycles into ON → `led_oe`=1 on that edge, `overrun`=1, `row_addr`=9 four edges later, new ON of `brightness<<2` cycles; then `overrun_clr` → `overrun`=0.
- `rst` pulsed mid-ON (between edges) → `led_oe`=1 immediately, `row_addr`=0, state IDLE.
- `brightness`=255 → `led_oe` low for exactly 1020 cycles; `enable` dropped mid-ON → `led_oe`=1 on the next edge and the following `lat_in` is ignored.
